axi_read_slave_mem: RTL and testbench

//  AXI4 read-channel slave backed by a word-addressed on-chip frame memory.
//  It sits directly downstream of the detector's AXI burst read master, accepting
//  AR requests and returning ARLEN+1 INCR beats with RLAST. A sideband preload port

---
 rtl/axi_obj_pkg.sv | 17 +
 rtl/axi_rd_mem_array.sv | 31 +++
 rtl/axi_read_slave_mem.sv | 140 ++++++++++++++
 tb/tb_axi_read_slave_mem.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_obj_pkg.sv
// Shared types for the AXI read slave: response codes, read FSM states and
// the AXI burst length field width.
package axi_obj_pkg;

    localparam int BEAT_LEN_W = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_t;

endpackage

// File: rtl/axi_rd_mem_array.sv
// Simple dual-port frame memory: one write port for preload and one read port
// with a registered output. A read and a write to the same word return the old data.
module axi_rd_mem_array
    import axi_obj_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-edge read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_read_slave_mem.sv
// AXI4 read-channel slave over an on-chip word memory: accepts one AR at a time
// and streams ARLEN+1 INCR beats, flagging beats outside the memory with SLVERR.
module axi_read_slave_mem
    import axi_obj_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [ADDR_W-1:0]            ARADDR,
    input  logic [BEAT_LEN_W-1:0]        ARLEN,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [DATA_W-1:0]            RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic                         RLAST,
    input  logic                         pl_we,
    input  logic [$clog2(MEM_WORDS)-1:0] pl_waddr,
    input  logic [DATA_W-1:0]            pl_wdata
);

    localparam int WORD_AW = $clog2(MEM_WORDS);
    localparam int BYTE_SH = $clog2(DATA_W / 8);

    rd_state_t             state, state_d;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    resp_t                 rresp_q;
    logic [ADDR_W-1:0]     word_q;
    logic                  below_q;
    logic [BEAT_LEN_W-1:0] len_q;
    logic [BEAT_LEN_W-1:0] count_q;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  fetch_en;
    logic [ADDR_W-1:0]     fetch_word;
    logic                  fetch_below;
    logic [BEAT_LEN_W-1:0] fetch_len;
    logic [BEAT_LEN_W-1:0] fetch_count;
    logic [DATA_W-1:0]     ram_q;

    // A beat is served only from inside the memory window; no wrap back into it.
    function automatic logic beat_ok(input logic below, input logic [ADDR_W-1:0] word);
        return !below && (word < ADDR_W'(MEM_WORDS));
    endfunction

    assign ar_hs = ARVALID && arready_q;
    assign r_hs  = rvalid_q && RREADY;

    // The memory is only read on AR or R handshakes, so its output holds during stalls.
    always_comb begin
        state_d     = state;
        fetch_en    = 1'b0;
        fetch_word  = word_q;
        fetch_below = below_q;
        fetch_len   = len_q;
        fetch_count = count_q;
        case (state)
            RD_IDLE: begin
                if (ar_hs) begin
                    state_d     = RD_BURST;
                    fetch_en    = 1'b1;
                    fetch_word  = (ARADDR - BASE_ADDR) >> BYTE_SH;
                    fetch_below = (ARADDR < BASE_ADDR);
                    fetch_len   = ARLEN;
                    fetch_count = '0;
                end
            end
            RD_BURST: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        state_d = RD_IDLE;
                    end else begin
                        fetch_en    = 1'b1;
                        fetch_word  = word_q + ADDR_W'(1);
                        fetch_count = count_q + BEAT_LEN_W'(1);
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            word_q    <= '0;
            below_q   <= 1'b0;
            len_q     <= '0;
            count_q   <= '0;
        end else begin
            state     <= state_d;
            arready_q <= (state_d == RD_IDLE);
            rvalid_q  <= (state_d == RD_BURST);
            if (fetch_en) begin
                word_q  <= fetch_word;
                below_q <= fetch_below;
                len_q   <= fetch_len;
                count_q <= fetch_count;
                rlast_q <= (fetch_count == fetch_len);
                rresp_q <= beat_ok(fetch_below, fetch_word) ? RESP_OKAY : RESP_SLVERR;
            end else if (state_d == RD_IDLE) begin
                rlast_q <= 1'b0;
                rresp_q <= RESP_OKAY;
            end
        end
    end

    axi_rd_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_WORDS),
        .AW     (WORD_AW)
    ) u_mem (
        .clk   (ACLK),
        .we    (pl_we),
        .waddr (pl_waddr),
        .wdata (pl_wdata),
        .re    (fetch_en),
        .raddr (fetch_word[WORD_AW-1:0]),
        .rdata (ram_q)
    );

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RDATA   = (rvalid_q && (rresp_q == RESP_OKAY)) ? ram_q : '0;

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// Directed bench for axi_read_slave_mem: bursts, backpressure, range errors,
// mid-burst reset, back-to-back AR and read-before-write preload.
module tb_axi_read_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic        pl_we;
    logic [9:0]  pl_waddr;
    logic [31:0] pl_wdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] bd [256];
    logic [1:0]  br [256];
    int          nb;

    always #5 ACLK = ~ACLK;

    axi_read_slave_mem dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .ARADDR   (ARADDR),
        .ARLEN    (ARLEN),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .RLAST    (RLAST),
        .pl_we    (pl_we),
        .pl_waddr (pl_waddr),
        .pl_wdata (pl_wdata)
    );

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_we    = 1'b1;
        pl_waddr = 10'(idx);
        pl_wdata = val;
        tick;
        pl_we    = 1'b0;
    endtask

    task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len);
        int n;
        n       = 0;
        ARADDR  = addr;
        ARLEN   = len;
        ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin
            tick;
            n++;
        end
        chk("ar_ready", 32'(ARREADY), 32'd1);
        tick;
        ARVALID = 1'b0;
        chk("r_latency", 32'(RVALID), 32'd1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        bit          stalled;
        int          cyc;
        hd = '0; hr = '0; hl = 1'b0;
        issue_ar(addr, len);
        nb      = 0;
        stalled = 1'b0;
        cyc     = 0;
        while (nb <= int'(len) && cyc < 2000) begin
            RREADY = toggle ? cyc[0] : 1'b1;
            if (!RVALID) begin
                chk("rvalid_on", 32'(RVALID), 32'd1);
                break;
            end
            if (stalled) begin
                chk("hold_data", RDATA, hd);
                chk("hold_resp", 32'(RRESP), 32'(hr));
                chk("hold_last", 32'(RLAST), 32'(hl));
            end
            if (RREADY) begin
                bd[nb] = RDATA;
                br[nb] = RRESP;
                chk("rlast_pos", 32'(RLAST), 32'(nb == int'(len)));
                nb++;
                stalled = 1'b0;
            end else begin
                hd = RDATA;
                hr = RRESP;
                hl = RLAST;
                stalled = 1'b1;
            end
            tick;
            cyc++;
        end
        RREADY = 1'b0;
        chk("beats", 32'(nb), 32'(int'(len) + 1));
        chk("rvalid_end", 32'(RVALID), 32'd0);
        chk("arready_end", 32'(ARREADY), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn  = 1'b0;
        ARADDR   = '0;
        ARLEN    = '0;
        ARVALID  = 1'b0;
        RREADY   = 1'b0;
        pl_we    = 1'b0;
        pl_waddr = '0;
        pl_wdata = '0;
        repeat (3) tick;

        // reset state
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rlast", 32'(RLAST), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_rresp", 32'(RRESP), 32'd0);
        ARESETn = 1'b1;
        chk("rel_arready0", 32'(ARREADY), 32'd0);
        tick;
        chk("rel_arready1", 32'(ARREADY), 32'd1);

        for (int i = 0; i < 16; i++) preload(i, 32'hA0 + 32'(i));
        preload(1022, 32'h55);
        preload(1023, 32'h66);

        // 16-beat burst, full throughput
        read_burst(32'h1000, 8'd15, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("t1_data", bd[i], 32'hA0 + 32'(i));
            chk("t1_resp", 32'(br[i]), 32'd0);
        end

        // same burst with RREADY toggling
        read_burst(32'h1000, 8'd15, 1'b1);
        for (int i = 0; i < 16; i++) chk("t2_data", bd[i], 32'hA0 + 32'(i));

        // burst running off the top of memory
        read_burst(32'h1000 + 32'd4 * 32'd1022, 8'd3, 1'b0);
        chk("t3_d0", bd[0], 32'h55);
        chk("t3_d1", bd[1], 32'h66);
        chk("t3_d2", bd[2], 32'h0);
        chk("t3_d3", bd[3], 32'h0);
        chk("t3_r0", 32'(br[0]), 32'd0);
        chk("t3_r1", 32'(br[1]), 32'd0);
        chk("t3_r2", 32'(br[2]), 32'd2);
        chk("t3_r3", 32'(br[3]), 32'd2);

        // address below the memory base
        read_burst(32'h0FF0, 8'd1, 1'b0);
        chk("lo_d0", bd[0], 32'h0);
        chk("lo_r0", 32'(br[0]), 32'd2);
        chk("lo_r1", 32'(br[1]), 32'd2);

        // reset in the middle of a burst
        issue_ar(32'h1000, 8'd15);
        RREADY = 1'b1;
        repeat (5) tick;
        chk("t4_beat5", RDATA, 32'hA5);
        ARESETn = 1'b0;
        #1;
        chk("t4_rvalid", 32'(RVALID), 32'd0);
        chk("t4_rlast", 32'(RLAST), 32'd0);
        chk("t4_rdata", RDATA, 32'd0);
        chk("t4_arready", 32'(ARREADY), 32'd0);
        RREADY = 1'b0;
        tick;
        ARESETn = 1'b1;
        tick;
        chk("t4_arready1", 32'(ARREADY), 32'd1);
        read_burst(32'h1000, 8'd0, 1'b0);
        chk("t4_word0", bd[0], 32'hA0);

        // back-to-back AR requests
        issue_ar(32'h1000, 8'd1);
        ARADDR  = 32'h1020;
        ARLEN   = 8'd1;
        ARVALID = 1'b1;
        RREADY  = 1'b1;
        chk("t5_d0", RDATA, 32'hA0);
        chk("t5_arr_a", 32'(ARREADY), 32'd0);
        tick;
        chk("t5_d1", RDATA, 32'hA1);
        chk("t5_last1", 32'(RLAST), 32'd1);
        chk("t5_arr_b", 32'(ARREADY), 32'd0);
        tick;
        chk("t5_gap", 32'(RVALID), 32'd0);
        chk("t5_arr_c", 32'(ARREADY), 32'd1);
        tick;
        ARVALID = 1'b0;
        chk("t5_v8", 32'(RVALID), 32'd1);
        chk("t5_d8", RDATA, 32'hA8);
        chk("t5_last8", 32'(RLAST), 32'd0);
        tick;
        chk("t5_d9", RDATA, 32'hA9);
        chk("t5_last9", 32'(RLAST), 32'd1);
        tick;
        chk("t5_end", 32'(RVALID), 32'd0);
        RREADY = 1'b0;

        // preload colliding with the fetch of beat 3
        issue_ar(32'h1000, 8'd5);
        RREADY = 1'b1;
        tick;
        tick;
        chk("t6_d2", RDATA, 32'hA2);
        pl_we    = 1'b1;
        pl_waddr = 10'd3;
        pl_wdata = 32'hDEAD_BEEF;
        tick;
        pl_we = 1'b0;
        chk("t6_old", RDATA, 32'hA3);
        tick;
        tick;
        chk("t6_d5", RDATA, 32'hA5);
        chk("t6_last", 32'(RLAST), 32'd1);
        tick;
        chk("t6_end", 32'(RVALID), 32'd0);
        RREADY = 1'b0;
        read_burst(32'h100C, 8'd0, 1'b0);
        chk("t6_new", bd[0], 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
